// File: rtl/program_loader_pkg.sv
// Shared types and constants for the UART-to-BRAM program loader.
package program_loader_pkg;

  localparam int unsigned BYTE_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_BITS  = 2;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-to-word shift register: packs bytes MSB-first and flags the last byte of a word.
module program_loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_shift,
  input  logic [BYTE_BITS-1:0] i_byte,
  output logic [DATA_BITS-1:0] o_word,
  output logic                 o_word_ready_c
);

  localparam logic [BYTE_CNT_BITS-1:0] LAST_BYTE = BYTE_CNT_BITS'(BYTES_PER_WORD - 1);

  logic [DATA_BITS-1:0]     word_q, word_d;
  logic [BYTE_CNT_BITS-1:0] cnt_q, cnt_d;

  // Shift in accepted bytes; the counter wraps to 0 after the last byte of a word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_shift) begin
      word_d = {word_q[DATA_BITS-BYTE_BITS-1:0], i_byte};
      cnt_d  = cnt_q + BYTE_CNT_BITS'(1);
    end
  end

  // Word and byte-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word         = word_q;
  assign o_word_ready_c = i_shift && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles UART bytes into words and writes them to BRAM from address 0.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned          ADDRESS_BITS = 8,
  parameter int unsigned          DATA_BITS    = 32,
  parameter logic [DATA_BITS-1:0] HALT_WORD    = DATA_BITS'(HALT_WORD_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_rx_done,
  input  logic [BYTE_BITS-1:0]    i_rx_data,
  output logic                    o_write_enable,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic [ADDRESS_BITS:0]   o_word_count
);

  localparam int unsigned             WC_BITS  = ADDRESS_BITS + 1;
  localparam logic [ADDRESS_BITS-1:0] ADDR_MAX = '1;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [WC_BITS-1:0]      wc_q, wc_d;
  logic                    ovf_q, ovf_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;

  logic [DATA_BITS-1:0]    asm_word;
  logic                    word_ready_c;
  logic                    write_cont_c;
  logic                    accept_c;
  logic                    clear_c;

  // A byte during WRITE counts only if the load continues into the next word.
  assign write_cont_c = (state_q == ST_WRITE) && i_enable &&
                        (asm_word != HALT_WORD) && (addr_q != ADDR_MAX);
  assign accept_c     = i_rx_done && i_enable && ((state_q == ST_RECV) || write_cont_c);
  assign clear_c      = (state_d == ST_IDLE);

  program_loader_word_assembler #(
    .DATA_BITS (DATA_BITS)
  ) u_asm (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (clear_c),
    .i_shift        (accept_c),
    .i_byte         (i_rx_data),
    .o_word         (asm_word),
    .o_word_ready_c (word_ready_c)
  );

  // Next-state, address, word count and status decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (!i_enable)         state_d = ST_IDLE;
        else if (word_ready_c) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wc_d = wc_q + WC_BITS'(1);
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (asm_word == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_MAX) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
        end else begin
          addr_d  = addr_q + ADDRESS_BITS'(1);
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        if (!i_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      addr_d = '0;
      wc_d   = '0;
      ovf_d  = 1'b0;
    end
    we_d   = (state_d == ST_WRITE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign o_write_enable = we_q;
  assign o_address      = addr_q;
  assign o_data         = asm_word;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;
  assign o_word_count   = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a byte-sequence reference model.
module tb_program_loader;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic          i_rx_done;
  logic [7:0]    i_rx_data;
  logic          o_write_enable;
  logic [AW-1:0] o_address;
  logic [DW-1:0] o_data;
  logic          o_done;
  logic          o_overflow;
  logic [AW:0]   o_word_count;

  always #5 clk = ~clk;

  program_loader #(
    .ADDRESS_BITS (AW),
    .DATA_BITS    (DW),
    .HALT_WORD    (HALT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_rx_done      (i_rx_done),
    .i_rx_data      (i_rx_data),
    .o_write_enable (o_write_enable),
    .o_address      (o_address),
    .o_data         (o_data),
    .o_done         (o_done),
    .o_overflow     (o_overflow),
    .o_word_count   (o_word_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural BRAM fed by the write port.
  logic [31:0] bram [DEPTH];
  always @(posedge clk) if (o_write_enable === 1'b1) bram[o_address] <= o_data;

  // Reference model: consumes the accepted byte sequence of one load.
  int          m_wc;
  int          m_cnt;
  logic [31:0] m_acc;
  bit          m_done;
  bit          m_ovf;
  wr_t         exp_q[$];
  logic [31:0] exp_mem [DEPTH];
  bit          exp_valid [DEPTH];

  task automatic model_reset();
    m_wc   = 0;
    m_cnt  = 0;
    m_acc  = '0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, output bit wrote);
    wr_t w;
    wrote = 1'b0;
    if (m_done) return;
    m_acc = {m_acc[23:0], b};
    m_cnt++;
    if (m_cnt == 4) begin
      m_cnt  = 0;
      w.addr = m_wc;
      w.data = m_acc;
      exp_q.push_back(w);
      exp_mem[m_wc]   = m_acc;
      exp_valid[m_wc] = 1'b1;
      wrote = 1'b1;
      m_wc++;
      if (m_acc == HALT) m_done = 1'b1;
      else if (m_wc == int'(DEPTH)) begin
        m_done = 1'b1;
        m_ovf  = 1'b1;
      end
    end
  endtask

  // Every write strobe must match the next expected (address, word) pair.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && o_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'(o_address), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(o_address), 64'(e.addr));
        chk("wr_data", 64'(o_data), 64'(e.data));
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit wrote;
    i_rx_done = 1'b1;
    i_rx_data = b;
    model_byte(b, wrote);
    @(negedge clk);
    i_rx_done = 1'b0;
    if (wrote) chk("wr_latency", 64'(o_write_enable), 64'd1);
  endtask

  task automatic start_load();
    i_enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic abort_load();
    i_enable = 1'b0;
    gap(2);
    chk("abort_flush", 64'(exp_q.size()), 64'd0);
    chk("abort_wc", 64'(o_word_count), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    model_reset();
  endtask

  task automatic check_end();
    gap(3);
    chk("done", 64'(o_done), 64'(m_done));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("word_count", 64'(o_word_count), 64'(m_wc));
    chk("address", 64'(o_address), 64'(m_done ? m_wc - 1 : m_wc));
    chk("pending", 64'(exp_q.size()), 64'd0);
    for (int a = 0; a < int'(DEPTH); a++)
      if (exp_valid[a]) chk("bram", 64'(bram[a]), 64'(exp_mem[a]));
  endtask

  task automatic end_load();
    i_enable = 1'b0;
    @(negedge clk);
    chk("drop_done", 64'(o_done), 64'd0);
    chk("drop_wc", 64'(o_word_count), 64'd0);
    chk("drop_addr", 64'(o_address), 64'd0);
    chk("drop_ovf", 64'(o_overflow), 64'd0);
    model_reset();
  endtask

  initial begin
    logic [7:0] dir_a [8];
    logic [7:0] b;
    int         nb;
    int         abort_at;
    bit         do_abort;
    bit         bias;

    rst       = 1'b1;
    i_enable  = 1'b0;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      exp_mem[a]   = '0;
      exp_valid[a] = 1'b0;
    end
    model_reset();
    gap(2);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_we", 64'(o_write_enable), 64'd0);
    chk("rst_addr", 64'(o_address), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_wc", 64'(o_word_count), 64'd0);

    // Asynchronous reset in the middle of a word
    start_load();
    send_byte(8'h20);
    send_byte(8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_we", 64'(o_write_enable), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    i_enable = 1'b0;
    model_reset();
    gap(2);
    rst = 1'b0;
    gap(2);
    chk("arst_nowrite_wc", 64'(o_word_count), 64'd0);

    // Program word then halt word, followed by the DONE hold
    dir_a = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(dir_a[i]);
      gap(1);
    end
    check_end();
    for (int i = 0; i < 10; i++) chk("done_hold", 64'(o_done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_hold_cyc", 64'(o_done), 64'd1);
    end
    send_byte(8'h12);
    gap(1);
    chk("done_ignores", 64'(o_word_count), 64'd2);
    end_load();

    // Fill memory without a halt word; trailing bytes are ignored
    start_load();
    for (int i = 0; i < 4 * int'(DEPTH); i++) send_byte(8'(i + 1));
    for (int i = 0; i < 4; i++) send_byte(8'h5A);
    check_end();
    end_load();

    // Back-to-back strobes, fifth byte lands during WRITE
    dir_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_load();
    for (int i = 0; i < 8; i++) send_byte(dir_a[i]);
    check_end();
    end_load();

    // Abort with a partial word, then a clean single word
    start_load();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    abort_load();
    start_load();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    check_end();
    end_load();

    // Randomised loads with random spacing, halt bias and aborts
    for (int s = 0; s < 30; s++) begin
      nb       = int'($urandom_range(0, 40));
      bias     = 1'($urandom_range(0, 1));
      do_abort = ($urandom_range(0, 4) == 0);
      abort_at = int'($urandom_range(0, 40));
      start_load();
      for (int i = 0; i < nb; i++) begin
        if (do_abort && i == abort_at) begin
          abort_load();
          break;
        end
        if (bias && $urandom_range(0, 1) == 1) b = 8'hFF;
        else b = 8'($urandom);
        send_byte(b);
        gap(int'($urandom_range(0, 2)));
      end
      check_end();
      end_load();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the instruction BRAM write port. Receives a byte stream from the UART receiver, assembles 32-bit instruction words MSB-first, and writes them to consecutive BRAM addresses starting at 0. Stops on the halt word or when memory is full, then flags completion to the debug/control unit, which releases the CPU from load mode.

## Interface

Parameters:

- ADDRESS_BITS, 8, BRAM word-address width (memory holds 2**ADDRESS_BITS words).
- DATA_BITS, 32, word width. Fixed at 4 bytes.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:

- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  load mode. Level-sensitive; deassertion aborts.
- i_rx_done  in  1  one-cycle strobe: i_rx_data is valid.
- i_rx_data  in  8  received byte.
- o_write_enable  out  1  BRAM write strobe (to BRAM write_enable).
- o_address  out  ADDRESS_BITS  BRAM word address (to BRAM i_address).
- o_data  out  DATA_BITS  assembled word (to BRAM i_data).
- o_done  out  1  load finished; held until i_enable drops.
- o_overflow  out  1  finished because memory filled without a halt word.
- o_word_count  out  ADDRESS_BITS+1  words written this load.

## Operation

- States:
  - IDLE: wait for i_enable=1. On entry: address, byte count and word count are 0.
  - RECV: collect bytes.
  - WRITE: assert the write strobe for exactly one cycle.
  - DONE: completion held.
- IDLE→RECV when i_enable=1.
- RECV: on each i_rx_done, o_data <= {o_data[23:0], i_rx_data}, so the first byte ends in bits [31:24]. Byte counter increments 0..3. On the 4th byte, go to WRITE.
- WRITE: o_write_enable=1, with o_address and o_data stable. At the closing edge:
  - o_word_count increments.
  - If o_data == HALT_WORD: go to DONE. The halt word is written to memory.
  - Else if o_address == 2**ADDRESS_BITS-1: go to DONE with o_overflow=1.
  - Else: o_address increments and the state returns to RECV.
- An i_rx_done arriving during WRITE is accepted as byte 0 of the next word (byte counter = 1). It is ignored if the block goes to DONE.
- DONE: o_done=1. Bytes are ignored. Go to IDLE when i_enable=0. o_overflow and o_word_count hold until IDLE is re-entered.
- i_enable=0 in RECV or WRITE: go to IDLE on the next edge.
  - A partial word is discarded and never written.
  - A write already in WRITE completes on that edge.
- o_address never wraps: the overflow stop precedes any increment past the maximum.

## Timing

- Reset values: state IDLE, o_write_enable=0, o_address=0, o_data=0, o_done=0, o_overflow=0, o_word_count=0.
- Latency: o_write_enable is high in the cycle immediately after the edge that samples the 4th i_rx_done.
- The BRAM captures the word on the next posedge, which is the same edge that advances o_address.
- o_done rises in the cycle after the last WRITE cycle.
- All outputs are registered or decoded from registered state only. No combinational path from the i_* inputs to the outputs.
- Minimum byte spacing: 1 cycle (back-to-back strobes are legal).

## Structure

- Shared Verilog header `loader_defs.vh`:
  - State encodings: IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3.
  - `HALT_WORD`.
  - `BYTES_PER_WORD`=4.
- One natural sub-module, `word_assembler`: an 8-to-32 shift register with a 2-bit byte counter and a word_ready pulse. The FSM, address and word counter stay in `program_loader`.

## Test plan

- Reset mid-RECV after 2 bytes → all outputs 0 immediately (asynchronous), state IDLE, no write.
- i_enable=1; bytes 20,01,00,05, FF,FF,FF,FF → writes 32'h20010005 @0, then 32'hFFFFFFFF @1; o_done=1, o_word_count=2, o_overflow=0; BRAM readback matches.
- ADDRESS_BITS=2; 16 non-halt bytes → 4 writes @0..3, o_overflow=1, o_done=1, o_address stays 3; a 17th byte is ignored.
- Back-to-back strobes (one per cycle, 8 bytes): the 5th byte lands during WRITE → two correct words @0,1; no byte lost.
- Abort: 3 bytes, then i_enable=0 → IDLE, no write. Re-enable and send 4 bytes → word written @0 with correct value, o_word_count=1.
- DONE hold: keep i_enable=1 for 10 cycles after halt → o_done stays 1. Drop i_enable → IDLE, o_done=0 next cycle.
